dsp_load_ctr_multi: RTL and testbench

Multi-channel loadable counter bank for the TPU address/weight sequencers: generalises the single loadable DSP-style counter to NUM_CHANNELS independent channels. Each channel adds a programmable step, an end value and a terminal-count mode (free-run, wrap-to-start, saturate). Channels share one clock and reset and drive the address generators for unified buffer and weight reads.

---
 rtl/tpu_pkg.sv | 9 +
 rtl/dsp_load_ctr_chan.sv | 72 +++++++
 rtl/dsp_load_ctr_multi.sv | 44 ++++
 tb/tb_dsp_load_ctr_multi.sv | 180 ++++++++++++++++++
 4 files changed

// File: rtl/tpu_pkg.sv
// tpu_pkg: shared types for the TPU address/weight sequencer counters
// ctr_mode_t: terminal-count behaviour of a counter channel; encoding 3 is unused and behaves as CTR_FREE
package tpu_pkg;
  typedef enum logic [1:0] {
    CTR_FREE = 2'd0,
    CTR_WRAP = 2'd1,
    CTR_SAT  = 2'd2
  } ctr_mode_t;
endpackage

// File: rtl/dsp_load_ctr_chan.sv
// dsp_load_ctr_chan: one loadable counter channel with step, end value and terminal mode
// clk, rst_n          : clock, asynchronous active-low reset
// enable, load        : channel enable (gates load and count), load strobe
// start_val, end_val  : loaded count / start shadow, terminal value
// step, mode          : increment and terminal mode, sampled on load
// ctr_val, tc, done   : registered count, one-cycle terminal pulse, saturate-reached level
module dsp_load_ctr_chan
  import tpu_pkg::*;
#(
  parameter int COUNTER_WIDTH = 32,
  parameter int STEP_WIDTH    = 8
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     enable,
  input  logic                     load,
  input  logic [COUNTER_WIDTH-1:0] start_val,
  input  logic [COUNTER_WIDTH-1:0] end_val,
  input  logic [STEP_WIDTH-1:0]    step,
  input  ctr_mode_t                mode,
  output logic [COUNTER_WIDTH-1:0] ctr_val,
  output logic                     tc,
  output logic                     done
);
  logic [COUNTER_WIDTH-1:0] r_ctr, r_start, r_end;
  logic [STEP_WIDTH-1:0]    r_step;
  ctr_mode_t                r_mode;
  logic                     r_tc, r_done;
  logic [COUNTER_WIDTH:0]   w_sum;
  logic [COUNTER_WIDTH-1:0] w_clamp, w_next_ctr;
  logic                     w_wrap, w_sat, w_at_end, w_next_tc, w_next_done;
  // The extra sum bit lets the clamp see overshoots past the top of the range
  always_comb begin
    w_sum       = {1'b0, r_ctr} + (COUNTER_WIDTH+1)'(r_step);
    w_wrap      = r_mode == CTR_WRAP;
    w_sat       = r_mode == CTR_SAT;
    w_at_end    = r_ctr == r_end;
    w_clamp     = (w_sum > {1'b0, r_end}) ? r_end : w_sum[COUNTER_WIDTH-1:0];
    w_next_ctr  = load ? start_val :
                  !(w_wrap || w_sat) ? w_sum[COUNTER_WIDTH-1:0] :
                  !w_at_end ? w_clamp :
                  w_wrap ? r_start : r_ctr;
    w_next_tc   = !load && w_at_end && (w_wrap || (w_sat && !r_done));
    w_next_done = !load && (r_done || (w_sat && w_at_end));
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ctr   <= '0;
      r_start <= '0;
      r_end   <= '0;
      r_step  <= STEP_WIDTH'(1);
      r_mode  <= CTR_FREE;
      r_tc    <= 1'b0;
      r_done  <= 1'b0;
    end else if (enable) begin
      r_ctr  <= w_next_ctr;
      r_tc   <= w_next_tc;
      r_done <= w_next_done;
      if (load) begin
        r_start <= start_val;
        r_end   <= end_val;
        r_step  <= step;
        r_mode  <= mode;
      end
    end else begin
      r_tc <= 1'b0;
    end
  end
  assign ctr_val = r_ctr;
  assign tc      = r_tc;
  assign done    = r_done;
endmodule

// File: rtl/dsp_load_ctr_multi.sv
// dsp_load_ctr_multi: bank of NUM_CHANNELS independent loadable counters
// clk, rst_n            : shared clock, asynchronous active-low reset
// enable, load          : per-channel enable and load strobe
// start_val, end_val    : per-channel start and terminal values
// step, mode            : per-channel increment and terminal mode
// ctr_val, tc, done     : per-channel registered count, terminal pulse, saturate-done level
module dsp_load_ctr_multi
  import tpu_pkg::*;
#(
  parameter int NUM_CHANNELS  = 4,
  parameter int COUNTER_WIDTH = 32,
  parameter int STEP_WIDTH    = 8
) (
  input  logic                                        clk,
  input  logic                                        rst_n,
  input  logic [NUM_CHANNELS-1:0]                     enable,
  input  logic [NUM_CHANNELS-1:0]                     load,
  input  logic [NUM_CHANNELS-1:0][COUNTER_WIDTH-1:0]  start_val,
  input  logic [NUM_CHANNELS-1:0][COUNTER_WIDTH-1:0]  end_val,
  input  logic [NUM_CHANNELS-1:0][STEP_WIDTH-1:0]     step,
  input  ctr_mode_t [NUM_CHANNELS-1:0]                mode,
  output logic [NUM_CHANNELS-1:0][COUNTER_WIDTH-1:0]  ctr_val,
  output logic [NUM_CHANNELS-1:0]                     tc,
  output logic [NUM_CHANNELS-1:0]                     done
);
  for (genvar i = 0; i < NUM_CHANNELS; i++) begin : g_chan
    dsp_load_ctr_chan #(
      .COUNTER_WIDTH(COUNTER_WIDTH),
      .STEP_WIDTH   (STEP_WIDTH)
    ) u_chan (
      .clk      (clk),
      .rst_n    (rst_n),
      .enable   (enable[i]),
      .load     (load[i]),
      .start_val(start_val[i]),
      .end_val  (end_val[i]),
      .step     (step[i]),
      .mode     (mode[i]),
      .ctr_val  (ctr_val[i]),
      .tc       (tc[i]),
      .done     (done[i])
    );
  end
endmodule

// File: tb/tb_dsp_load_ctr_multi.sv
// tb_dsp_load_ctr_multi: vector table, corner sequences and random traffic against a behavioural model
module tb_dsp_load_ctr_multi;
  import tpu_pkg::*;
  localparam int N = 4;
  localparam int W = 8;
  localparam int S = 8;
  typedef struct {
    logic       en, ld;
    logic [7:0] sv, ev, sp;
    logic [1:0] md;
    logic [7:0] xc;
    logic       xt, xd;
  } vec_t;
  logic                clk = 1'b0;
  logic                rst_n = 1'b0;
  logic [N-1:0]        enable = '0;
  logic [N-1:0]        load = '0;
  logic [N-1:0][W-1:0] start_val = '0;
  logic [N-1:0][W-1:0] end_val = '0;
  logic [N-1:0][S-1:0] step = '0;
  ctr_mode_t [N-1:0]   mode;
  logic [N-1:0][W-1:0] ctr_val;
  logic [N-1:0]        tc, done;
  int n_chk = 0;
  int n_pass = 0;
  int m_ctr[N], m_st[N], m_end[N], m_stp[N], m_md[N], m_tc[N], m_done[N];
  vec_t tbl[$];
  dsp_load_ctr_multi #(.NUM_CHANNELS(N), .COUNTER_WIDTH(W), .STEP_WIDTH(S)) dut (
    .clk(clk), .rst_n(rst_n), .enable(enable), .load(load), .start_val(start_val),
    .end_val(end_val), .step(step), .mode(mode), .ctr_val(ctr_val), .tc(tc), .done(done)
  );
  always #5 clk = ~clk;
  task automatic chk(string nm, int ch, int act, int exp);
    n_chk++;
    if (act == exp) n_pass++;
    else $display("FAIL %s ch/row %0d: got %0d expected %0d", nm, ch, act, exp);
  endtask
  function automatic void m_reset();
    for (int c = 0; c < N; c++) begin
      m_ctr[c] = 0; m_st[c] = 0; m_end[c] = 0; m_stp[c] = 1; m_md[c] = 0; m_tc[c] = 0; m_done[c] = 0;
    end
  endfunction
  function automatic void m_edge();
    for (int c = 0; c < N; c++) begin
      int nxt, lim, md;
      if (!enable[c]) m_tc[c] = 0;
      else if (load[c]) begin
        m_ctr[c] = int'(start_val[c]); m_st[c] = int'(start_val[c]); m_end[c] = int'(end_val[c]);
        m_stp[c] = int'(step[c]); m_md[c] = int'(mode[c]); m_done[c] = 0; m_tc[c] = 0;
      end else begin
        md  = (m_md[c] == 1 || m_md[c] == 2) ? m_md[c] : 0;
        nxt = m_ctr[c] + m_stp[c];
        lim = (nxt > m_end[c]) ? m_end[c] : nxt;
        if (md == 0) begin
          m_ctr[c] = nxt % (1 << W); m_tc[c] = 0;
        end else if (m_ctr[c] == m_end[c]) begin
          if (md == 1) begin m_ctr[c] = m_st[c]; m_tc[c] = 1; end
          else begin m_tc[c] = m_done[c] ? 0 : 1; m_done[c] = 1; end
        end else begin
          m_ctr[c] = lim; m_tc[c] = 0;
        end
      end
    end
  endfunction
  task automatic cyc();
    @(posedge clk);
    m_edge();
    #1;
    for (int c = 0; c < N; c++) begin
      chk("ctr", c, int'(ctr_val[c]), m_ctr[c]);
      chk("tc", c, int'(tc[c]), m_tc[c]);
      chk("done", c, int'(done[c]), m_done[c]);
    end
  endtask
  task automatic chk_zero(string nm);
    for (int c = 0; c < N; c++) begin
      chk({nm, "_ctr"}, c, int'(ctr_val[c]), 0);
      chk({nm, "_tc"}, c, int'(tc[c]), 0);
      chk({nm, "_done"}, c, int'(done[c]), 0);
    end
  endtask
  function automatic vec_t v(int en, int ld, int sv, int ev, int sp, int md, int xc, int xt, int xd);
    vec_t r;
    r.en = en[0]; r.ld = ld[0]; r.sv = sv[7:0]; r.ev = ev[7:0]; r.sp = sp[7:0];
    r.md = md[1:0]; r.xc = xc[7:0]; r.xt = xt[0]; r.xd = xd[0];
    return r;
  endfunction
  initial begin
    for (int c = 0; c < N; c++) mode[c] = CTR_FREE;
    tbl.push_back(v(1,0,0,0,0,0, 1,0,0));
    tbl.push_back(v(1,0,0,0,0,0, 2,0,0));
    tbl.push_back(v(1,0,0,0,0,0, 3,0,0));
    tbl.push_back(v(1,0,0,0,0,0, 4,0,0));
    tbl.push_back(v(0,1,5,200,10,2, 4,0,0));
    tbl.push_back(v(1,0,0,0,0,0, 5,0,0));
    tbl.push_back(v(1,1,2,10,3,1, 2,0,0));
    tbl.push_back(v(1,0,0,0,0,0, 5,0,0));
    tbl.push_back(v(1,0,0,0,0,0, 8,0,0));
    tbl.push_back(v(1,0,0,0,0,0, 10,0,0));
    tbl.push_back(v(1,0,0,0,0,0, 2,1,0));
    tbl.push_back(v(1,0,0,0,0,0, 5,0,0));
    tbl.push_back(v(1,1,250,255,4,2, 250,0,0));
    tbl.push_back(v(1,0,0,0,0,0, 254,0,0));
    tbl.push_back(v(1,0,0,0,0,0, 255,0,0));
    tbl.push_back(v(1,0,0,0,0,0, 255,1,1));
    tbl.push_back(v(1,0,0,0,0,0, 255,0,1));
    tbl.push_back(v(0,0,0,0,0,0, 255,0,1));
    tbl.push_back(v(1,1,254,0,3,0, 254,0,0));
    tbl.push_back(v(1,0,0,0,0,0, 1,0,0));
    tbl.push_back(v(1,0,0,0,0,0, 4,0,0));
    tbl.push_back(v(1,1,9,4,0,1, 9,0,0));
    tbl.push_back(v(1,0,0,0,0,0, 4,0,0));
    tbl.push_back(v(1,0,0,0,0,0, 9,1,0));
    tbl.push_back(v(1,0,0,0,0,0, 4,0,0));
    tbl.push_back(v(1,1,7,7,2,1, 7,0,0));
    tbl.push_back(v(1,0,0,0,0,0, 7,1,0));
    tbl.push_back(v(1,0,0,0,0,0, 7,1,0));
    tbl.push_back(v(1,1,0,2,5,3, 0,0,0));
    tbl.push_back(v(1,0,0,0,0,0, 5,0,0));
    tbl.push_back(v(1,0,0,0,0,0, 10,0,0));
    m_reset();
    #3;
    chk_zero("reset");
    #9;
    rst_n = 1'b1;
    foreach (tbl[k]) begin
      enable = '0; load = '0;
      enable[0] = tbl[k].en; load[0] = tbl[k].ld;
      start_val[0] = tbl[k].sv; end_val[0] = tbl[k].ev; step[0] = tbl[k].sp;
      mode[0] = ctr_mode_t'(tbl[k].md);
      cyc();
      chk("tbl_ctr", k, int'(ctr_val[0]), int'(tbl[k].xc));
      chk("tbl_tc", k, int'(tc[0]), int'(tbl[k].xt));
      chk("tbl_done", k, int'(done[0]), int'(tbl[k].xd));
    end
    enable = '1; load = '1;
    start_val[0] = 8'd2;   end_val[0] = 8'd10;  step[0] = 8'd3; mode[0] = CTR_WRAP;
    start_val[1] = 8'd250; end_val[1] = 8'd255; step[1] = 8'd4; mode[1] = CTR_SAT;
    start_val[2] = 8'd254; end_val[2] = 8'd0;   step[2] = 8'd3; mode[2] = CTR_FREE;
    start_val[3] = 8'd0;   end_val[3] = 8'd0;   step[3] = 8'd1; mode[3] = CTR_FREE;
    cyc();
    load = '0;
    cyc();
    cyc();
    chk("conc_wrap", 0, int'(ctr_val[0]), 8);
    chk("conc_sat", 1, int'(ctr_val[1]), 255);
    chk("conc_free", 2, int'(ctr_val[2]), 4);
    chk("conc_free_tc", 2, int'(tc[2]), 0);
    cyc();
    cyc();
    chk("conc_wrap_ret", 0, int'(ctr_val[0]), 2);
    chk("conc_wrap_tc", 0, int'(tc[0]), 1);
    chk("conc_sat_done", 1, int'(done[1]), 1);
    cyc();
    #2;
    rst_n = 1'b0;
    #1;
    chk_zero("async_rst");
    m_reset();
    #2;
    rst_n = 1'b1;
    cyc();
    chk("post_rst_1", 0, int'(ctr_val[0]), 1);
    cyc();
    chk("post_rst_2", 0, int'(ctr_val[0]), 2);
    for (int k = 0; k < 400; k++) begin
      for (int c = 0; c < N; c++) begin
        enable[c] = $urandom_range(0, 7) != 0;
        load[c] = $urandom_range(0, 9) == 0;
        start_val[c] = 8'($urandom_range(0, 255));
        end_val[c] = 8'(int'(start_val[c]) + $urandom_range(0, 40));
        step[c] = 8'($urandom_range(0, 9));
        mode[c] = ctr_mode_t'($urandom_range(0, 3));
      end
      cyc();
    end
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
